mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit
Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles mem_req waits for mem_ack before abort.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  pipeline presents a load/store request.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_load  input  1  1=load (LDR/LDRB), 0=store (STR/STRB).
REQ-008 req_byte  input  1  1=byte access, 0=word access.
REQ-009 req_addr  input  32  byte address from the datapath output.
REQ-010 req_wdata  input  32  store data from the datapath store-data port.
REQ-011 req_rd  input  4  load destination register.
REQ-012 mem_req  output  1  memory request, held until acknowledged.
REQ-013 mem_we  output  1  1=write.
REQ-014 mem_addr  output  11  word address = req_addr[12:2].
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_wdata  output  32  write data.
REQ-017 mem_ack  input  1  memory completed the current request.
REQ-018 mem_rdata  input  32  read word, valid with mem_ack.
REQ-019 w_en_ldr, w_addr_ldr[3:0], w_data_ldr[31:0]  outputs  load writeback to the regfile load write port.
REQ-020 busy  output  1  request in flight; pipeline stalls while high.
REQ-021 err  output  1  one-cycle pulse: misaligned word access or timeout.
Function
REQ-022 SHALL use FSM states IDLE, ACCESS, WB; req_ready=1 only in IDLE; busy = not IDLE.
REQ-023 Acceptance when req_valid&&req_ready at a clock edge; all req_* fields captured at that edge and held internally.
REQ-024 Accepted word access with req_addr[1:0]!=0 SHALL NOT issue mem_req; err pulses the next cycle and FSM stays IDLE.
REQ-025 Otherwise FSM enters ACCESS; mem_req, mem_we, mem_addr, mem_be, and mem_wdata are registered and valid in the first ACCESS cycle; all stay stable until ack.
REQ-026 Word store: mem_be=4'b1111, mem_wdata=req_wdata; byte store: mem_be one-hot at addr[1:0], mem_wdata = req_wdata[7:0] replicated x4.
REQ-027 Loads: mem_we=0, mem_be=4'b1111.
REQ-028 mem_ack is sampled only while mem_req=1; otherwise it is ignored.
REQ-029 Store with ack: mem_req drops next cycle and FSM returns to IDLE; no writeback.
REQ-030 Load with ack: mem_rdata is registered; next cycle is WB with w_en_ldr=1 for exactly one cycle, w_addr_ldr=req_rd, then IDLE.
REQ-031 Load data: word = mem_rdata; byte = zero-extended lane addr[1:0] (lane 0 = bits 7:0).
REQ-032 Timeout counter clears on entry to ACCESS; if TIMEOUT_CYCLES cycles pass without ack, drop mem_req, pulse err, go IDLE, no writeback.
REQ-033 Ack in the same cycle as the timeout terminal count SHALL complete normally (ack wins).
REQ-034 Latency: acceptance edge N -> mem_req at N+1; ack sampled at edge M -> w_en_ldr high in cycle after M; back-to-back request acceptable in the cycle after WB/store completion.
Reset
REQ-035 rst_n low SHALL immediately force IDLE; mem_req, mem_we, w_en_ldr, busy, and err go to 0; all data/address/be outputs go to 0; counter goes to 0; req_ready goes to 1 after release.
REQ-036 Reset mid-ACCESS SHALL abandon the request with no writeback; an ack arriving after reset is ignored.
Structure
REQ-037 Package mem_pkg SHALL hold the FSM state enum, TIMEOUT_CYCLES default, and BE_WORD constant.
REQ-038 Byte-lane extract/replicate logic SHALL be one sub-module, mem_lane_align.
Verification
REQ-039 Load word at addr 0x40, ack after 3 cycles, rdata 0xDEADBEEF, rd=5 -> mem_addr=0x10, one w_en_ldr pulse with w_addr_ldr=5 and w_data_ldr=0xDEADBEEF.
REQ-040 LDRB at addr 0x43, rdata 0xAABBCCDD -> w_data_ldr=0x000000AA.
REQ-041 STRB at addr 0x81, wdata 0x12345677 -> mem_be=4'b0010, mem_wdata=0x77777777, mem_we=1, w_en_ldr never asserted.
REQ-042 Word load at addr 0x42 -> no mem_req, err pulses for 1 cycle, req_ready stays 1.
REQ-043 No ack with TIMEOUT_CYCLES=4 -> mem_req drops after 4 cycles with err pulse; separately, rst_n low mid-ACCESS -> all outputs go to 0 asynchronously.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_lane_align.sv | 30 +++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store memory access unit.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WB     = 2'd2
   } mau_state_e;

   localparam int         TIMEOUT_CYCLES_DEFAULT = 255;
   localparam logic [3:0] BE_WORD                = 4'b1111;

endpackage : mem_pkg

// File: rtl/mem_access_unit_if.sv
// Pipeline request, memory bus and load-writeback signals of mem_access_unit.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_rd;

   logic        mem_req;
   logic        mem_we;
   logic [10:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        w_en_ldr;
   logic [3:0]  w_addr_ldr;
   logic [31:0] w_data_ldr;
   logic        busy;
   logic        err;

   // The unit itself: consumes requests and acks, drives the bus and writeback.
   modport slave (
      input  req_valid, req_load, req_byte, req_addr, req_wdata, req_rd,
      input  mem_ack, mem_rdata,
      output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output w_en_ldr, w_addr_ldr, w_data_ldr, busy, err
   );

   // The surrounding pipeline and memory model.
   modport master (
      output req_valid, req_load, req_byte, req_addr, req_wdata, req_rd,
      output mem_ack, mem_rdata,
      input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  w_en_ldr, w_addr_ldr, w_data_ldr, busy, err
   );

endinterface : mem_access_unit_if

// File: rtl/mem_lane_align.sv
// Byte-lane handling: store byte enables/replication and load lane extraction.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic        st_byte_i,
   input  logic [1:0]  st_lane_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_data_o,
   input  logic        ld_byte_i,
   input  logic [1:0]  ld_lane_i,
   input  logic [31:0] ld_data_i,
   output logic [31:0] ld_data_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      st_be_o   = BE_WORD;
      st_data_o = st_data_i;
      ld_data_o = ld_data_i;
      if (st_byte_i) begin
         st_be_o   = 4'b0001 << st_lane_i;
         st_data_o = {4{st_data_i[7:0]}};
      end
      if (ld_byte_i) begin
         ld_data_o = {24'h0, ld_data_i[{ld_lane_i, 3'b000} +: 8]};
      end
   end

endmodule : mem_lane_align

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, word/byte access, ack timeout, load writeback.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);

   localparam int               CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   mau_state_e  state_q;
   logic        mem_req_q, mem_we_q;
   logic [10:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic        w_en_q;
   logic [3:0]  w_addr_q;
   logic [31:0] w_data_q;
   logic        err_q;
   logic        load_q, byte_q;
   logic [1:0]  lane_q;
   logic [3:0]  rd_q;
   logic [CNT_W-1:0] cnt_q;

   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;
   logic        misaligned;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^bus.req_addr[31:13];
   assign misaligned       = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);

   mem_lane_align u_lane_align (
      .st_byte_i (bus.req_byte),
      .st_lane_i (bus.req_addr[1:0]),
      .st_data_i (bus.req_wdata),
      .st_be_o   (st_be),
      .st_data_o (st_wdata),
      .ld_byte_i (byte_q),
      .ld_lane_i (lane_q),
      .ld_data_i (bus.mem_rdata),
      .ld_data_o (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         w_en_q      <= 1'b0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         err_q       <= 1'b0;
         load_q      <= 1'b0;
         byte_q      <= 1'b0;
         lane_q      <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         err_q  <= 1'b0;
         w_en_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  if (misaligned) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q     <= ACCESS;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= !bus.req_load;
                     mem_addr_q  <= bus.req_addr[12:2];
                     mem_be_q    <= bus.req_load ? BE_WORD : st_be;
                     mem_wdata_q <= st_wdata;
                     load_q      <= bus.req_load;
                     byte_q      <= bus.req_byte;
                     lane_q      <= bus.req_addr[1:0];
                     rd_q        <= bus.req_rd;
                     cnt_q       <= '0;
                  end
               end
            end
            ACCESS: begin
               // Ack is checked before the terminal count so a last-cycle ack still completes.
               if (mem_req_q && bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (load_q) begin
                     w_en_q   <= 1'b1;
                     w_addr_q <= rd_q;
                     w_data_q <= ld_data;
                     state_q  <= WB;
                  end else begin
                     state_q  <= IDLE;
                  end
               end else if (cnt_q == CNT_MAX) begin
                  mem_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            WB:      state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.w_en_ldr   = w_en_q;
   assign bus.w_addr_ldr = w_addr_q;
   assign bus.w_data_ldr = w_data_q;
   assign bus.err        = err_q;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a writeback scoreboard; timeout set to 4 cycles.
module tb_mem_access_unit;
   import mem_pkg::*;

   typedef struct packed {
      logic [3:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if u_if ();

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   int  n_checks = 0;
   int  n_fail   = 0;
   wb_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every writeback pulse must match the oldest outstanding load.
   always @(negedge clk) begin
      wb_t e;
      if (u_if.w_en_ldr === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected", 32'(u_if.w_en_ldr), 32'd0);
         end else begin
            e = sb.pop_front();
            check("wb_addr", 32'(u_if.w_addr_ldr), 32'(e.rd));
            check("wb_data", u_if.w_data_ldr, e.data);
         end
      end
   end

   task automatic access(input logic ld, input logic bt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] rd, input int ack_after,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_ld);
      @(negedge clk);
      u_if.req_valid = 1'b1;
      u_if.req_load  = ld;
      u_if.req_byte  = bt;
      u_if.req_addr  = addr;
      u_if.req_wdata = wdata;
      u_if.req_rd    = rd;
      if (ld) sb.push_back('{rd: rd, data: exp_ld});
      @(negedge clk);
      u_if.req_valid = 1'b0;
      check("acc_mem_req", 32'(u_if.mem_req), 32'd1);
      check("acc_mem_we", 32'(u_if.mem_we), 32'(!ld));
      check("acc_mem_addr", 32'(u_if.mem_addr), 32'(addr[12:2]));
      check("acc_mem_be", 32'(u_if.mem_be), 32'(exp_be));
      check("acc_busy", 32'(u_if.busy), 32'd1);
      check("acc_ready", 32'(u_if.req_ready), 32'd0);
      if (!ld) check("acc_mem_wdata", u_if.mem_wdata, exp_wd);
      for (int i = 1; i < ack_after; i++) begin
         @(negedge clk);
         check("acc_req_hold", 32'(u_if.mem_req), 32'd1);
      end
      u_if.mem_ack   = 1'b1;
      u_if.mem_rdata = rdata;
      @(negedge clk);
      u_if.mem_ack   = 1'b0;
      u_if.mem_rdata = 32'h0;
      check("done_mem_req", 32'(u_if.mem_req), 32'd0);
      check("done_err", 32'(u_if.err), 32'd0);
      check("done_busy", 32'(u_if.busy), 32'(ld));
      if (ld) begin
         @(negedge clk);
         check("wb_exit_busy", 32'(u_if.busy), 32'd0);
      end
      check("done_ready", 32'(u_if.req_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      u_if.req_valid = 1'b0;
      u_if.req_load  = 1'b0;
      u_if.req_byte  = 1'b0;
      u_if.req_addr  = 32'h0;
      u_if.req_wdata = 32'h0;
      u_if.req_rd    = 4'h0;
      u_if.mem_ack   = 1'b0;
      u_if.mem_rdata = 32'h0;

      #12;
      check("rst_mem_req", 32'(u_if.mem_req), 32'd0);
      check("rst_busy", 32'(u_if.busy), 32'd0);
      check("rst_err", 32'(u_if.err), 32'd0);
      check("rst_w_en", 32'(u_if.w_en_ldr), 32'd0);
      check("rst_mem_addr", 32'(u_if.mem_addr), 32'd0);
      check("rst_mem_be", 32'(u_if.mem_be), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", 32'(u_if.req_ready), 32'd1);

      // Word load at 0x40, ack in third ACCESS cycle.
      access(1'b1, 1'b0, 32'h40, 32'h0, 4'd5, 3, 32'hDEADBEEF, BE_WORD, 32'h0, 32'hDEADBEEF);
      // Byte loads: top lane and bottom lane.
      access(1'b1, 1'b1, 32'h43, 32'h0, 4'd7, 1, 32'hAABBCCDD, BE_WORD, 32'h0, 32'h000000AA);
      access(1'b1, 1'b1, 32'h44, 32'h0, 4'd2, 2, 32'hAABBCCDD, BE_WORD, 32'h0, 32'h000000DD);
      // Byte store and word store.
      access(1'b0, 1'b1, 32'h81, 32'h12345677, 4'd0, 2, 32'h0, 4'b0010, 32'h77777777, 32'h0);
      access(1'b0, 1'b0, 32'h84, 32'hCAFEF00D, 4'd0, 1, 32'h0, BE_WORD, 32'hCAFEF00D, 32'h0);
      // Ack on the terminal-count cycle completes normally.
      access(1'b1, 1'b0, 32'h1FFC, 32'h0, 4'd9, 4, 32'h0BADF00D, BE_WORD, 32'h0, 32'h0BADF00D);

      // Misaligned word load: err pulse, no request.
      @(negedge clk);
      u_if.req_valid = 1'b1;
      u_if.req_load  = 1'b1;
      u_if.req_byte  = 1'b0;
      u_if.req_addr  = 32'h42;
      @(negedge clk);
      u_if.req_valid = 1'b0;
      check("mis_err", 32'(u_if.err), 32'd1);
      check("mis_mem_req", 32'(u_if.mem_req), 32'd0);
      check("mis_ready", 32'(u_if.req_ready), 32'd1);
      @(negedge clk);
      check("mis_err_clear", 32'(u_if.err), 32'd0);
      check("mis_mem_req2", 32'(u_if.mem_req), 32'd0);

      // Store with no ack times out after 4 cycles.
      u_if.req_valid = 1'b1;
      u_if.req_load  = 1'b0;
      u_if.req_byte  = 1'b0;
      u_if.req_addr  = 32'h100;
      u_if.req_wdata = 32'h55AA55AA;
      @(negedge clk);
      u_if.req_valid = 1'b0;
      check("to_req_1", 32'(u_if.mem_req), 32'd1);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         check("to_req_hold", 32'(u_if.mem_req), 32'd1);
         check("to_no_err", 32'(u_if.err), 32'd0);
      end
      @(negedge clk);
      check("to_req_drop", 32'(u_if.mem_req), 32'd0);
      check("to_err", 32'(u_if.err), 32'd1);
      check("to_busy", 32'(u_if.busy), 32'd0);
      u_if.mem_ack = 1'b1;
      @(negedge clk);
      u_if.mem_ack = 1'b0;
      check("to_err_clear", 32'(u_if.err), 32'd0);
      check("idle_ack_ignored", 32'(u_if.busy), 32'd0);

      // Reset in the middle of a load abandons it.
      u_if.req_valid = 1'b1;
      u_if.req_load  = 1'b1;
      u_if.req_byte  = 1'b0;
      u_if.req_addr  = 32'h200;
      u_if.req_rd    = 4'd3;
      @(negedge clk);
      u_if.req_valid = 1'b0;
      check("mr_req", 32'(u_if.mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_mem_req", 32'(u_if.mem_req), 32'd0);
      check("mr_mem_we", 32'(u_if.mem_we), 32'd0);
      check("mr_busy", 32'(u_if.busy), 32'd0);
      check("mr_err", 32'(u_if.err), 32'd0);
      check("mr_w_en", 32'(u_if.w_en_ldr), 32'd0);
      check("mr_mem_addr", 32'(u_if.mem_addr), 32'd0);
      check("mr_mem_be", 32'(u_if.mem_be), 32'd0);
      check("mr_mem_wdata", u_if.mem_wdata, 32'd0);
      check("mr_w_addr", 32'(u_if.w_addr_ldr), 32'd0);
      check("mr_w_data", u_if.w_data_ldr, 32'd0);
      u_if.mem_ack   = 1'b1;
      u_if.mem_rdata = 32'h13579BDF;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      u_if.mem_ack = 1'b0;
      check("post_rst_busy", 32'(u_if.busy), 32'd0);
      check("post_rst_req", 32'(u_if.mem_req), 32'd0);
      check("post_rst_ready", 32'(u_if.req_ready), 32'd1);

      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_access_unit
